// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - two-road traffic phase sequencer with BCD countdown and pedestrian short green
module traffic_phase_ctrl #(
    parameter logic [7:0] GREEN_T   = 8'h25,
    parameter logic [7:0] YELLOW_T  = 8'h03,
    parameter logic [7:0] ALLRED_T  = 8'h02,
    parameter logic [7:0] PED_SHORT = 8'h05
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [3:0] cnt_tens,
    output logic [3:0] cnt_ones,
    output logic       phase_done
);

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR1  = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR2  = 3'd5
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_dec_d;
    logic [7:0] dur_d;
    logic [2:0] ns_q, ew_q, ns_d, ew_d;
    logic       walk_q, done_q, ped_pend_q;
    logic       ped_any, short_green, state_valid;

    // state_d is the successor phase, used only when the count expires
    always_comb begin
        state_d = AR2;
        case (state_q)
            NS_G:    state_d = NS_Y;
            NS_Y:    state_d = AR1;
            AR1:     state_d = EW_G;
            EW_G:    state_d = EW_Y;
            EW_Y:    state_d = AR2;
            AR2:     state_d = NS_G;
            default: state_d = AR2;
        endcase
    end

    always_comb begin
        dur_d = ALLRED_T;
        ns_d  = 3'b100;
        ew_d  = 3'b100;
        case (state_d)
            NS_G:    begin dur_d = GREEN_T;  ns_d = 3'b001; end
            NS_Y:    begin dur_d = YELLOW_T; ns_d = 3'b010; end
            EW_G:    begin dur_d = GREEN_T;  ew_d = 3'b001; end
            EW_Y:    begin dur_d = YELLOW_T; ew_d = 3'b010; end
            default: dur_d = ALLRED_T;
        endcase
    end

    always_comb begin
        if (cnt_q[3:0] == 4'd0) begin
            cnt_dec_d = {cnt_q[7:4] - 4'd1, 4'd9};
        end else begin
            cnt_dec_d = {cnt_q[7:4], cnt_q[3:0] - 4'd1};
        end
    end

    // valid BCD compares correctly as plain binary
    assign ped_any     = ped_pend_q | ped_req;
    assign short_green = (state_q == NS_G) && ped_any && (cnt_q > PED_SHORT);
    assign state_valid = state_q inside {NS_G, NS_Y, AR1, EW_G, EW_Y, AR2};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= AR2;
            cnt_q      <= ALLRED_T;
            ns_q       <= 3'b100;
            ew_q       <= 3'b100;
            walk_q     <= 1'b0;
            done_q     <= 1'b0;
            ped_pend_q <= 1'b0;
        end else if (!state_valid) begin
            state_q    <= AR2;
            cnt_q      <= ALLRED_T;
            ns_q       <= 3'b100;
            ew_q       <= 3'b100;
            walk_q     <= 1'b0;
            done_q     <= 1'b0;
            ped_pend_q <= ped_any;
        end else begin
            done_q <= 1'b0;
            if (ped_req) begin
                ped_pend_q <= 1'b1;
            end
            if (tick) begin
                if (cnt_q == 8'h01) begin
                    state_q <= state_d;
                    cnt_q   <= dur_d;
                    ns_q    <= ns_d;
                    ew_q    <= ew_d;
                    done_q  <= 1'b1;
                    if (state_d == EW_G) begin
                        walk_q     <= ped_any;
                        ped_pend_q <= 1'b0;
                    end else begin
                        walk_q <= 1'b0;
                    end
                end else if (short_green) begin
                    cnt_q <= PED_SHORT;
                end else begin
                    cnt_q <= cnt_dec_d;
                end
            end
        end
    end

    assign ns_light   = ns_q;
    assign ew_light   = ew_q;
    assign walk       = walk_q;
    assign cnt_tens   = cnt_q[7:4];
    assign cnt_ones   = cnt_q[3:0];
    assign phase_done = done_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - vector table, directed sequences and random run against a phase/seconds model
module tb_traffic_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst, tick, ped_req;
    logic [2:0] ns_light, ew_light;
    logic       walk, phase_done;
    logic [3:0] cnt_tens, cnt_ones;

    int tests = 0;
    int fails = 0;

    traffic_phase_ctrl dut (
        .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req),
        .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
        .cnt_tens(cnt_tens), .cnt_ones(cnt_ones), .phase_done(phase_done)
    );

    always #5 clk = ~clk;

    // phase index 0..5 = NS_G, NS_Y, AR1, EW_G, EW_Y, AR2; m_rem is seconds left as an integer
    int dur [6] = '{25, 3, 2, 25, 3, 2};
    int m_ph, m_rem;
    bit m_walk, m_done, m_pend;

    function automatic logic [2:0] lamp_ns(input int ph);
        return (ph == 0) ? 3'b001 : (ph == 1) ? 3'b010 : 3'b100;
    endfunction

    function automatic logic [2:0] lamp_ew(input int ph);
        return (ph == 3) ? 3'b001 : (ph == 4) ? 3'b010 : 3'b100;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    task automatic model_step(input bit r, input bit t, input bit p);
        bit new_pend;
        if (r) begin
            m_ph = 5; m_rem = 2; m_walk = 0; m_done = 0; m_pend = 0;
        end else begin
            m_done   = 0;
            new_pend = m_pend | p;
            if (t) begin
                if (m_rem == 1) begin
                    m_ph   = (m_ph + 1) % 6;
                    m_rem  = dur[m_ph];
                    m_done = 1;
                    if (m_ph == 3) begin
                        m_walk   = m_pend | p;
                        new_pend = 0;
                    end else begin
                        m_walk = 0;
                    end
                end else if (m_ph == 0 && (m_pend | p) && m_rem > 5) begin
                    m_rem = 5;
                end else begin
                    m_rem = m_rem - 1;
                end
            end
            m_pend = new_pend;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit t, input bit p);
        rst = r; tick = t; ped_req = p;
        model_step(r, t, p);
        @(posedge clk);
        #1;
        chk("model", {ns_light, ew_light, walk, cnt_tens, cnt_ones, phase_done},
            {lamp_ns(m_ph), lamp_ew(m_ph), m_walk, to_bcd(m_rem), m_done});
        chk("bcd_valid", {31'd0, (cnt_tens <= 4'd9) && (cnt_ones <= 4'd9) && ({cnt_tens, cnt_ones} != 8'h00)}, 32'd1);
    endtask

    task automatic tick_until(input int ph, input int rem);
        int n = 0;
        while (!(m_ph == ph && m_rem == rem) && n < 300) begin
            step(0, 1, 0);
            n++;
        end
        if (n >= 300) begin
            tests++;
            fails++;
            $display("FAIL reach: phase %0d count %0d not reached within 300 ticks", ph, rem);
        end
    endtask

    typedef struct {
        bit         r, t, p;
        logic [2:0] ns, ew;
        logic       wk;
        logic [7:0] cnt;
        logic       done;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit walk_seen;
        rst = 1'b1; tick = 1'b0; ped_req = 1'b0;

        vecs[0] = '{1, 0, 0, 3'b100, 3'b100, 0, 8'h02, 0};
        vecs[1] = '{1, 1, 1, 3'b100, 3'b100, 0, 8'h02, 0};
        vecs[2] = '{0, 0, 0, 3'b100, 3'b100, 0, 8'h02, 0};
        vecs[3] = '{0, 1, 0, 3'b100, 3'b100, 0, 8'h01, 0};
        vecs[4] = '{0, 1, 0, 3'b001, 3'b100, 0, 8'h25, 1};
        vecs[5] = '{0, 0, 0, 3'b001, 3'b100, 0, 8'h25, 0};
        vecs[6] = '{0, 1, 0, 3'b001, 3'b100, 0, 8'h24, 0};
        vecs[7] = '{0, 1, 0, 3'b001, 3'b100, 0, 8'h23, 0};

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].r, vecs[i].t, vecs[i].p);
            chk($sformatf("vec%0d", i), {ns_light, ew_light, walk, cnt_tens, cnt_ones, phase_done},
                {vecs[i].ns, vecs[i].ew, vecs[i].wk, vecs[i].cnt, vecs[i].done});
        end

        // BCD rollover 20 -> 19 -> ... -> 10 -> 09, then NS_Y at 03
        tick_until(0, 20);
        step(0, 1, 0);
        chk("roll_19", {cnt_tens, cnt_ones}, 8'h19);
        tick_until(0, 10);
        step(0, 1, 0);
        chk("roll_09", {cnt_tens, cnt_ones}, 8'h09);
        tick_until(0, 1);
        step(0, 1, 0);
        chk("ns_y_entry", {ns_light, cnt_tens, cnt_ones}, {3'b010, 8'h03});

        // full 60-tick cycle with no pedestrian
        tick_until(0, 25);
        walk_seen = 0;
        for (int i = 0; i < 60; i++) begin
            step(0, 1, 0);
            walk_seen |= walk;
        end
        chk("full_cycle", {ns_light, ew_light, cnt_tens, cnt_ones}, {3'b001, 3'b100, 8'h25});
        chk("full_walk", {31'd0, walk_seen}, 32'd0);

        // pedestrian at 18 truncates green to 05
        tick_until(0, 18);
        step(0, 0, 1);
        step(0, 1, 0);
        chk("short_05", {cnt_tens, cnt_ones}, 8'h05);
        step(0, 1, 0);
        chk("short_04", {cnt_tens, cnt_ones}, 8'h04);
        tick_until(3, 25);
        chk("walk_on", {ew_light, walk, phase_done}, {3'b001, 1'b1, 1'b1});
        walk_seen = 1;
        for (int i = 0; i < 24; i++) begin
            step(0, 1, 0);
            walk_seen &= walk;
        end
        chk("walk_held", {31'd0, walk_seen}, 32'd1);
        step(0, 1, 0);
        chk("walk_off", {ew_light, walk}, {3'b010, 1'b0});

        // late pedestrian: normal decrement, walk in following EW_G
        tick_until(0, 4);
        step(0, 0, 1);
        step(0, 1, 0);
        chk("late_03", {cnt_tens, cnt_ones}, 8'h03);
        tick_until(3, 24);
        chk("late_walk", {31'd0, walk}, 32'd1);

        // reset mid EW_G with walk high, tick and ped_req coincident
        step(1, 1, 1);
        chk("rst_mid", {ns_light, ew_light, walk, cnt_tens, cnt_ones}, {3'b100, 3'b100, 1'b0, 8'h02});
        tick_until(3, 25);
        chk("rst_pend_clr", {31'd0, walk}, 32'd0);

        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Traffic-light phase sequencer for a two-road intersection (north-south and east-west).
- Sits directly downstream of the seconds-tick chain and consumes its 1 Hz terminal-count pulse as `tick`.
- Holds a two-digit BCD down-counter with the seconds remaining in the current phase and drives both roads' lamps, a pedestrian WALK lamp, and the BCD digits for the countdown display.

Parameters:
- GREEN_T, 8'h25, green duration in seconds as two BCD digits {tens,ones}; must be valid BCD, 8'h06..8'h99.
- YELLOW_T, 8'h03, yellow duration, BCD, nonzero.
- ALLRED_T, 8'h02, all-red clearance duration, BCD, nonzero.
- PED_SHORT, 8'h05, NS green is truncated to this value on a pedestrian request; BCD, nonzero, < GREEN_T.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous active-high reset.
- tick  input  1  one-second pulse, one clk wide, from the upstream BCD seconds counter.
- ped_req  input  1  pedestrian button, level or pulse, synchronised upstream.
- ns_light  output  3  {red,yellow,green} for the NS road, one-hot.
- ew_light  output  3  {red,yellow,green} for the EW road, one-hot.
- walk  output  1  pedestrian WALK lamp for crossing the NS road.
- cnt_tens  output  4  BCD tens digit of seconds remaining.
- cnt_ones  output  4  BCD ones digit of seconds remaining.
- phase_done  output  1  one-cycle pulse in the cycle after a phase change.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst and has priority over all other inputs.
- Reset values:
  - State = AR2.
  - {cnt_tens,cnt_ones} = ALLRED_T.
  - ns_light = ew_light = 3'b100.
  - walk = 0, phase_done = 0, ped_pend = 0.
- All outputs are registered.
- States and cyclic sequence: NS_G -> NS_Y -> AR1 -> EW_G -> EW_Y -> AR2 -> NS_G.
- Lamps per state:
  - NS_G: ns=001, ew=100.
  - NS_Y: ns=010, ew=100.
  - AR1 and AR2: both 100.
  - EW_G: ns=100, ew=001.
  - EW_Y: ns=100, ew=010.
- Countdown:
  - The counter changes only in a cycle with tick=1.
  - Count 8'h01 on a tick: load the next state's duration and move to the next state. Lamps, count and phase_done=1 are all visible on the following edge.
  - Otherwise, decrement in BCD: if ones is 0, ones becomes 9 and tens decrements; else ones decrements. Example: 8'h20 -> 8'h19.
  - The count 00 is never displayed or held.
- tick held high: every high cycle counts as one tick. No edge detection.
- Pedestrian latch:
  - ped_pend is set by ped_req=1 in any cycle and is sticky.
  - ped_pend is cleared in the cycle EW_G is entered.
- Short green:
  - Condition: state NS_G, tick=1, (ped_pend or ped_req), and count > PED_SHORT (BCD magnitude compare).
  - Result: the count is loaded with PED_SHORT instead of decrementing. The reduction is applied at most once, because afterwards count <= PED_SHORT.
- walk:
  - Set on entry to EW_G if ped_pend or ped_req is 1 in the transition cycle.
  - Held for the whole of EW_G and cleared on entry to EW_Y.
  - Never 1 in any other state.
- ped_req during EW_G: sets ped_pend for the next cycle. It does not extend the current walk.
- Reset mid-phase: the next edge forces the reset values regardless of tick or ped_req.
- Invalid state encoding: recover to AR2 with count ALLRED_T.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles, then release; 2 ticks.
  - Required: ns=ew=100 and count=02 after reset; count=01 after the first tick; after the second tick, state NS_G with ns=001, count=25 and phase_done pulsed for one cycle.
- BCD rollover:
  - Stimulus: ticks in NS_G.
  - Required: 25,24,...,21,20,19,...,10,09,...,01; the next tick gives NS_Y with count 03. No non-BCD nibble ever appears.
- Full cycle, no pedestrian:
  - Stimulus: 25+3+2+25+3+2 = 60 ticks from NS_G entry.
  - Required: return to NS_G with count 25; walk stays 0 throughout.
- Pedestrian short green:
  - Stimulus: ped_req pulse at count 18 in NS_G.
  - Required: the next tick gives count 05 (not 17); the sequence 04..01 then follows; NS_Y 03..01 and AR1 02..01 follow; walk=1 on EW_G entry for all 25 seconds; walk=0 at EW_Y.
- Late pedestrian:
  - Stimulus: ped_req at count 04 in NS_G.
  - Required: normal decrement to 03; walk=1 during the following EW_G.
- Reset mid EW_G with walk=1, tick coincident with rst:
  - Required: next cycle both roads 100, walk=0, count=02, ped_pend=0.
